// File: rtl/freq_meas_ctrl.sv
`timescale 1ns/1ps
// freq_meas_ctrl
// Measurement sequencer for the equal-precision frequency meter. It opens a
// preset gate on the gate/counter datapath and clears its counters. It picks
// the direct or /16 prescaled path from the returned M/N counts, using
// hysteresis and at most one range switch per measurement. Each scaled M/N
// result is offered downstream through a valid/ready handshake.
//
// Ports:
//   clk_50M, rst        system clock, asynchronous active-high reset
//   start, cont         single-shot request, continuous mode
//   gate_sel[1:0]       preset gate length select (sampled in CLEAR)
//   gate_pre, clr_cnt   preset gate and counter clear to the datapath
//   div_sel             0 = direct path, 1 = /16 prescaled path
//   gate_real           precise gate returned by the datapath
//   M_in, N_in          reference and input counts from the datapath
//   M_out, N_out        latched result (N_out rescaled to direct-path units)
//   range_out, err_noin path used for the result, no-input/timeout flag
//   result_valid/ready  result handshake
//   busy                high whenever the sequencer is not idle
module freq_meas_ctrl #(
  parameter int unsigned GATE_TIMEOUT = 100_000_000,
  parameter int unsigned GATE_LEN0    = 500_000,
  parameter int unsigned GATE_LEN1    = 5_000_000,
  parameter int unsigned GATE_LEN2    = 50_000_000
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic [1:0]  gate_sel,
  output logic        gate_pre,
  output logic        clr_cnt,
  output logic        div_sel,
  input  logic        gate_real,
  input  logic [31:0] M_in,
  input  logic [31:0] N_in,
  output logic [31:0] M_out,
  output logic [31:0] N_out,
  output logic        range_out,
  output logic        err_noin,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy
);

  localparam int unsigned GL_MAX01 = (GATE_LEN0 > GATE_LEN1) ? GATE_LEN0 : GATE_LEN1;
  localparam int unsigned GL_MAX   = (GL_MAX01 > GATE_LEN2) ? GL_MAX01 : GATE_LEN2;
  localparam int unsigned GC_W     = $clog2(GL_MAX + 1);
  localparam int unsigned TO_W     = $clog2(GATE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_OPEN, S_CLOSE, S_EVAL, S_PRESENT
  } state_t;

  state_t          r_state;
  logic [GC_W-1:0] r_gate_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_gate_prev;
  logic            r_seen_rise;
  logic            r_close_first;
  logic            r_noin;
  logic            r_sw_used;
  logic            r_gate_pre;
  logic            r_clr_cnt;
  logic            r_div_sel;
  logic [31:0]     r_m_out;
  logic [31:0]     r_n_out;
  logic            r_range;
  logic            r_err;
  logic            r_valid;
  logic            r_busy;

  logic [GC_W-1:0] w_gate_load;
  logic            w_rise;
  logic            w_fall;
  logic [39:0]     w_n_x4;
  logic [39:0]     w_n_x128;
  logic [39:0]     w_m_ext;
  logic            w_go_up;
  logic            w_go_dn;

  // Gate counter preload: counts down to zero, so L-1 gives L open cycles.
  always_comb begin
    w_gate_load = GC_W'(GATE_LEN2 - 1);
    case (gate_sel)
      2'b00:   w_gate_load = GC_W'(GATE_LEN0 - 1);
      2'b01:   w_gate_load = GC_W'(GATE_LEN1 - 1);
      default: w_gate_load = GC_W'(GATE_LEN2 - 1);
    endcase
  end

  assign w_rise = gate_real & ~r_gate_prev;
  assign w_fall = r_gate_prev & ~gate_real;

  // 40-bit range products: N*4 > M means f > 12.5 MHz, N*128 < M means f < 6.25 MHz.
  assign w_n_x4   = {6'd0, N_in, 2'b00};
  assign w_n_x128 = {1'b0, N_in, 7'd0};
  assign w_m_ext  = {8'd0, M_in};
  assign w_go_up  = ~r_div_sel & (w_n_x4 > w_m_ext) & ~r_sw_used;
  assign w_go_dn  = r_div_sel & (w_n_x128 < w_m_ext) & ~r_sw_used;

  // Sequencer with registered outputs.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_gate_cnt    <= '0;
      r_to_cnt      <= '0;
      r_gate_prev   <= 1'b0;
      r_seen_rise   <= 1'b0;
      r_close_first <= 1'b0;
      r_noin        <= 1'b0;
      r_sw_used     <= 1'b0;
      r_gate_pre    <= 1'b0;
      r_clr_cnt     <= 1'b0;
      r_div_sel     <= 1'b0;
      r_m_out       <= '0;
      r_n_out       <= '0;
      r_range       <= 1'b0;
      r_err         <= 1'b0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_gate_prev <= gate_real;
      r_clr_cnt   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sw_used <= 1'b0;
          if (start || cont) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_gate_cnt  <= w_gate_load;
          r_seen_rise <= 1'b0;
          r_gate_pre  <= 1'b1;
          r_state     <= S_OPEN;
        end
        S_OPEN: begin
          if (w_rise) r_seen_rise <= 1'b1;
          if (r_gate_cnt == '0) begin
            r_gate_pre    <= 1'b0;
            r_close_first <= 1'b1;
            r_to_cnt      <= '0;
            r_state       <= S_CLOSE;
          end else begin
            r_gate_cnt <= r_gate_cnt - GC_W'(1);
          end
        end
        S_CLOSE: begin
          r_close_first <= 1'b0;
          // No rise during the gate and still low on entry: nothing to wait for.
          if (r_close_first && !r_seen_rise && !gate_real) begin
            r_noin  <= 1'b1;
            r_state <= S_EVAL;
          end else if (w_fall) begin
            r_noin  <= 1'b0;
            r_state <= S_EVAL;
          end else if (r_to_cnt == TO_W'(GATE_TIMEOUT - 1)) begin
            r_noin  <= 1'b1;
            r_state <= S_EVAL;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_EVAL: begin
          if (r_noin) begin
            r_m_out <= M_in;
            r_n_out <= '0;
            r_range <= r_div_sel;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end else if (w_go_up) begin
            r_div_sel <= 1'b1;
            r_sw_used <= 1'b1;
            r_clr_cnt <= 1'b1;
            r_state   <= S_CLEAR;
          end else if (w_go_dn) begin
            r_div_sel <= 1'b0;
            r_sw_used <= 1'b1;
            r_clr_cnt <= 1'b1;
            r_state   <= S_CLEAR;
          end else begin
            r_m_out <= M_in;
            r_n_out <= r_div_sel ? (N_in << 4) : N_in;
            r_range <= r_div_sel;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (result_ready) begin
            r_valid   <= 1'b0;
            r_sw_used <= 1'b0;
            if (cont) begin
              r_clr_cnt <= 1'b1;
              r_state   <= S_CLEAR;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_gate_pre <= 1'b0;
          r_valid    <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign gate_pre     = r_gate_pre;
  assign clr_cnt      = r_clr_cnt;
  assign div_sel      = r_div_sel;
  assign M_out        = r_m_out;
  assign N_out        = r_n_out;
  assign range_out    = r_range;
  assign err_noin     = r_err;
  assign result_valid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
`timescale 1ns/1ps
// Bench for freq_meas_ctrl: a behavioural datapath drives gate_real and M/N
// counts from a chosen input frequency; expected range, window count and
// result come from frequency bands and the recorded datapath counts.
module tb_freq_meas_ctrl;

  localparam int GL0 = 2000;
  localparam int GL1 = 3000;
  localparam int GL2 = 4000;
  localparam int TO  = 300;
  localparam int WAIT_LIMIT = 12000;
  localparam int MODE_NORMAL = 0;
  localparam int MODE_LOW    = 1;
  localparam int MODE_STUCK  = 2;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [1:0]  gate_sel = 2'b00;
  logic        gate_pre;
  logic        clr_cnt;
  logic        div_sel;
  logic        gate_real = 1'b0;
  logic [31:0] M_in = '0;
  logic [31:0] N_in = '0;
  logic [31:0] M_out;
  logic [31:0] N_out;
  logic        range_out;
  logic        err_noin;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;

  freq_meas_ctrl #(
    .GATE_TIMEOUT(TO), .GATE_LEN0(GL0), .GATE_LEN1(GL1), .GATE_LEN2(GL2)
  ) dut (
    .clk_50M(clk_50M), .rst(rst), .start(start), .cont(cont), .gate_sel(gate_sel),
    .gate_pre(gate_pre), .clr_cnt(clr_cnt), .div_sel(div_sel), .gate_real(gate_real),
    .M_in(M_in), .N_in(N_in), .M_out(M_out), .N_out(N_out), .range_out(range_out),
    .err_noin(err_noin), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct {
    int   m;
    int   n;
    logic dv;
    int   gp_len;
    int   fall_cyc;
    int   gpfall_cyc;
  } win_t;

  win_t win_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   freq_khz = 1000;
  int   dp_mode = MODE_NORMAL;
  logic model_div = 1'b0;

  // datapath model state
  logic   gp_prev = 1'b0;
  logic   win_dv = 1'b0;
  int     rise_cd = -1;
  int     fall_cd = -1;
  int     m_cnt = 0;
  int     gp_len = 0;
  longint nd;
  win_t   cur;

  always @(posedge clk_50M) cyc = cyc + 1;

  // Behavioural gate/counter datapath, updated away from the active edge.
  always @(negedge clk_50M) begin
    if (rst) begin
      gate_real = 1'b0;
      gp_prev   = 1'b0;
      rise_cd   = -1;
      fall_cd   = -1;
      m_cnt     = 0;
      gp_len    = 0;
    end else begin
      if (clr_cnt) begin
        M_in = '0;
        N_in = '0;
      end
      if (gate_pre && !gp_prev) begin
        win_dv  = div_sel;
        gp_len  = 0;
        m_cnt   = 0;
        fall_cd = -1;
        rise_cd = (dp_mode == MODE_LOW) ? -1 : int'($urandom_range(5, 1));
      end
      if (gate_pre) gp_len++;
      if (!gate_pre && gp_prev) begin
        cur.gp_len     = gp_len;
        cur.dv         = win_dv;
        cur.gpfall_cyc = cyc;
        if (dp_mode == MODE_NORMAL) begin
          fall_cd = int'($urandom_range(4, 0));
        end else begin
          M_in         = 32'($urandom_range(900000, 1000));
          N_in         = 32'($urandom_range(5000, 1));
          cur.m        = int'(M_in);
          cur.n        = 0;
          cur.fall_cyc = cyc;
          win_q.push_back(cur);
        end
      end
      if (rise_cd > 0) rise_cd--;
      else if (rise_cd == 0) begin
        gate_real = 1'b1;
        rise_cd   = -1;
      end
      if (gate_real) m_cnt++;
      if (fall_cd == 0) begin
        gate_real    = 1'b0;
        fall_cd      = -1;
        nd           = (longint'(m_cnt) * freq_khz) / 50000;
        M_in         = 32'(m_cnt);
        N_in         = win_dv ? 32'(nd / 16) : 32'(nd);
        cur.m        = m_cnt;
        cur.n        = int'(N_in);
        cur.fall_cyc = cyc;
        win_q.push_back(cur);
      end else if (fall_cd > 0) begin
        fall_cd--;
      end
      // leftover high level after a stuck-gate scenario
      if (dp_mode == MODE_NORMAL && gate_real && !gate_pre && fall_cd < 0 && rise_cd < 0)
        gate_real = 1'b0;
      gp_prev = gate_pre;
    end
  end

  function automatic int len_of(input logic [1:0] g);
    case (g)
      2'b00:   return GL0;
      2'b01:   return GL1;
      default: return GL2;
    endcase
  endfunction

  // One start-triggered measurement at input frequency f_khz.
  task automatic run_measure(input int f_khz, input logic [1:0] gsel, input int hold,
                             input string tag);
    int base, t, nw, exp_len, exp_win;
    logic exp_rng;
    logic [31:0] exp_m, exp_n;
    win_t w;
    exp_len = len_of(gsel);
    if (f_khz < 6250) exp_rng = 1'b0;
    else if (f_khz > 12500) exp_rng = 1'b1;
    else exp_rng = model_div;
    exp_win  = (exp_rng == model_div) ? 1 : 2;
    freq_khz = f_khz;
    dp_mode  = MODE_NORMAL;
    gate_sel = gsel;
    base     = win_q.size();
    @(negedge clk_50M); start = 1'b1;
    @(negedge clk_50M); start = 1'b0;
    checks++;
    if (clr_cnt !== 1'b1) begin
      errors++; $display("FAIL %s clr_cnt_latency got=%b exp=1", tag, clr_cnt);
    end
    @(negedge clk_50M);
    checks++;
    if (gate_pre !== 1'b1 || clr_cnt !== 1'b0) begin
      errors++; $display("FAIL %s gate_open got gate_pre=%b clr=%b exp 1/0", tag, gate_pre, clr_cnt);
    end
    t = 0;
    while (result_valid !== 1'b1 && t < WAIT_LIMIT) begin
      @(negedge clk_50M); t++;
    end
    checks++;
    if (result_valid !== 1'b1) begin
      errors++; $display("FAIL %s result_timeout got valid=%b exp=1", tag, result_valid);
      return;
    end
    nw = win_q.size() - base;
    checks++;
    if (nw != exp_win) begin
      errors++; $display("FAIL %s windows got=%0d exp=%0d", tag, nw, exp_win);
    end
    for (int i = base; i < win_q.size(); i++) begin
      checks++;
      if (win_q[i].gp_len != exp_len) begin
        errors++; $display("FAIL %s gate_len got=%0d exp=%0d", tag, win_q[i].gp_len, exp_len);
      end
    end
    if (nw > 0) begin
      w = win_q[win_q.size()-1];
      exp_m = 32'(w.m);
      exp_n = w.dv ? 32'(w.n << 4) : 32'(w.n);
      checks++;
      if (w.dv !== exp_rng || range_out !== exp_rng) begin
        errors++; $display("FAIL %s range got path=%b range_out=%b exp=%b", tag, w.dv, range_out, exp_rng);
      end
      checks++;
      if (M_out !== exp_m || N_out !== exp_n || err_noin !== 1'b0) begin
        errors++; $display("FAIL %s result got M=%0d N=%0d err=%b exp M=%0d N=%0d err=0",
                           tag, M_out, N_out, err_noin, exp_m, exp_n);
      end
      checks++;
      if (cyc != w.fall_cyc + 2) begin
        errors++; $display("FAIL %s valid_latency got=%0d exp=%0d", tag, cyc, w.fall_cyc + 2);
      end
      repeat (hold) @(negedge clk_50M);
      checks++;
      if (result_valid !== 1'b1 || M_out !== exp_m || N_out !== exp_n) begin
        errors++; $display("FAIL %s hold got valid=%b M=%0d N=%0d exp 1/%0d/%0d",
                           tag, result_valid, M_out, N_out, exp_m, exp_n);
      end
    end
    result_ready = 1'b1;
    @(negedge clk_50M); result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || clr_cnt !== 1'b0) begin
      errors++; $display("FAIL %s after_handshake got valid=%b busy=%b clr=%b exp 0/0/0",
                         tag, result_valid, busy, clr_cnt);
    end
    model_div = exp_rng;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_50M);
    checks++;
    if ({gate_pre, clr_cnt, div_sel, range_out, err_noin, result_valid, busy} !== 7'b0 ||
        M_out !== 32'd0 || N_out !== 32'd0) begin
      errors++; $display("FAIL reset_values got gp=%b clr=%b div=%b rng=%b err=%b v=%b busy=%b M=%0d N=%0d",
                         gate_pre, clr_cnt, div_sel, range_out, err_noin, result_valid, busy, M_out, N_out);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk_50M);
    checks++;
    if (busy !== 1'b0 || clr_cnt !== 1'b0) begin
      errors++; $display("FAIL idle_no_start got busy=%b clr=%b exp 0/0", busy, clr_cnt);
    end
  endtask

  task automatic test_single();
    run_measure(1000, 2'b00, 8, "single_1mhz");
  endtask

  task automatic test_up_switch();
    run_measure(20000, 2'b00, 2, "up_20mhz");
  endtask

  task automatic test_hold_band();
    run_measure(9000, 2'b00, 1, "band_from_hi");
    run_measure(1000, 2'b01, 1, "down_1mhz");
    run_measure(9000, 2'b00, 1, "band_from_lo");
  endtask

  task automatic test_random();
    int c, f;
    logic [1:0] g;
    for (int k = 0; k < 5; k++) begin
      c = int'($urandom_range(2, 0));
      if (c == 0) f = int'($urandom_range(6000, 300));
      else if (c == 1) f = int'($urandom_range(12000, 7000));
      else f = int'($urandom_range(40000, 13500));
      g = 2'($urandom_range(3, 0));
      run_measure(f, g, int'($urandom_range(4, 0)), "random");
    end
  endtask

  // Abnormal gate: MODE_LOW never raises gate_real, MODE_STUCK never drops it.
  task automatic noin_case(input int mode, input int exp_lat, input string tag);
    int base, t;
    win_t w;
    dp_mode  = mode;
    gate_sel = 2'b00;
    base     = win_q.size();
    @(negedge clk_50M); start = 1'b1;
    @(negedge clk_50M); start = 1'b0;
    t = 0;
    while (result_valid !== 1'b1 && t < WAIT_LIMIT) begin
      @(negedge clk_50M); t++;
    end
    checks++;
    if (result_valid !== 1'b1 || win_q.size() != base + 1) begin
      errors++; $display("FAIL %s result got valid=%b windows=%0d exp 1/1", tag, result_valid, win_q.size() - base);
      dp_mode = MODE_NORMAL;
      return;
    end
    w = win_q[base];
    checks++;
    if (cyc != w.gpfall_cyc + exp_lat) begin
      errors++; $display("FAIL %s latency got=%0d exp=%0d", tag, cyc - w.gpfall_cyc, exp_lat);
    end
    checks++;
    if (err_noin !== 1'b1 || N_out !== 32'd0 || M_out !== 32'(w.m) || range_out !== model_div) begin
      errors++; $display("FAIL %s fields got err=%b N=%0d M=%0d rng=%b exp 1/0/%0d/%b",
                         tag, err_noin, N_out, M_out, range_out, w.m, model_div);
    end
    result_ready = 1'b1;
    @(negedge clk_50M); result_ready = 1'b0;
    dp_mode = MODE_NORMAL;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s release got valid=%b busy=%b exp 0/0", tag, result_valid, busy);
    end
    repeat (3) @(negedge clk_50M);
  endtask

  task automatic test_noin();
    noin_case(MODE_LOW, 2, "noin_low");
  endtask

  task automatic test_timeout();
    noin_case(MODE_STUCK, TO + 1, "stuck_high");
  endtask

  task automatic test_back_to_back();
    int base, t;
    logic exp_clr;
    dp_mode  = MODE_NORMAL;
    freq_khz = 9000;
    gate_sel = 2'b00;
    base     = win_q.size();
    result_ready = 1'b1;
    @(negedge clk_50M); cont = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) cont = 1'b0;
      t = 0;
      while (result_valid !== 1'b1 && t < WAIT_LIMIT) begin
        @(negedge clk_50M); t++;
      end
      checks++;
      if (result_valid !== 1'b1 || win_q.size() != base + k + 1) begin
        errors++; $display("FAIL b2b_result%0d got valid=%b windows=%0d exp 1/%0d",
                           k, result_valid, win_q.size() - base, k + 1);
        break;
      end
      checks++;
      if (M_out !== 32'(win_q[base+k].m) || range_out !== model_div) begin
        errors++; $display("FAIL b2b_value%0d got M=%0d rng=%b exp %0d/%b",
                           k, M_out, range_out, win_q[base+k].m, model_div);
      end
      exp_clr = (k < 3);
      @(negedge clk_50M);
      checks++;
      if (result_valid !== 1'b0 || clr_cnt !== exp_clr || busy !== exp_clr) begin
        errors++; $display("FAIL b2b_restart%0d got valid=%b clr=%b busy=%b exp 0/%b/%b",
                           k, result_valid, clr_cnt, busy, exp_clr, exp_clr);
      end
      if (k < 3) begin
        repeat (20) @(negedge clk_50M);
        start = 1'b1;
        @(negedge clk_50M); start = 1'b0;
        checks++;
        if (clr_cnt !== 1'b0 || gate_pre !== 1'b1) begin
          errors++; $display("FAIL b2b_start_ignored%0d got clr=%b gate_pre=%b exp 0/1", k, clr_cnt, gate_pre);
        end
      end
    end
    result_ready = 1'b0;
    cont = 1'b0;
    for (int i = base; i < win_q.size(); i++) begin
      checks++;
      if (win_q[i].gp_len != GL0) begin
        errors++; $display("FAIL b2b_gate_len got=%0d exp=%0d", win_q[i].gp_len, GL0);
      end
    end
    repeat (3) @(negedge clk_50M);
  endtask

  task automatic test_reset_mid();
    if (model_div !== 1'b1) run_measure(20000, 2'b00, 0, "pre_reset_up");
    freq_khz = 1000;
    dp_mode  = MODE_NORMAL;
    gate_sel = 2'b00;
    @(negedge clk_50M); start = 1'b1;
    @(negedge clk_50M); start = 1'b0;
    repeat (50) @(negedge clk_50M);
    checks++;
    if (gate_pre !== 1'b1 || div_sel !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got gate_pre=%b div=%b exp 1/1", gate_pre, div_sel);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({gate_pre, clr_cnt, div_sel, range_out, err_noin, result_valid, busy} !== 7'b0 ||
        M_out !== 32'd0 || N_out !== 32'd0) begin
      errors++; $display("FAIL rst_mid_async got gp=%b clr=%b div=%b rng=%b err=%b v=%b busy=%b",
                         gate_pre, clr_cnt, div_sel, range_out, err_noin, result_valid, busy);
    end
    @(negedge clk_50M);
    @(negedge clk_50M); rst = 1'b0;
    model_div = 1'b0;
    @(negedge clk_50M);
    run_measure(1000, 2'b00, 1, "post_reset");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_up_switch();
    test_hold_band();
    test_random();
    test_noin();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
# freq_meas_ctrl

Measurement sequencer for the equal-precision frequency meter. It drives the preset gate and counter clear of one gate/counter datapath and selects between the direct input path and the ÷16 prescaled path. It auto-ranges on the returned M/N counts and delivers each scaled M/N result pair downstream, for example to the divider/display stage, through a valid/ready handshake. It replaces the free-running, combinational M/N path selection in the meter top level.

## Interface
Parameters:
- GATE_TIMEOUT, 100_000_000: maximum clk_50M cycles to wait for gate_real to fall after gate_pre drops.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin one measurement; ignored unless the FSM is in IDLE.
- cont  in  1  continuous mode; when high, a new measurement starts automatically after each accepted result.
- gate_sel  in  2  preset gate length: 00 = 500_000, 01 = 5_000_000, 10 = 50_000_000, 11 = 50_000_000 cycles.
- gate_pre  out  1  preset gate to the datapath.
- clr_cnt  out  1  one-cycle clear pulse to the datapath M/N counters.
- div_sel  out  1  path select: 0 = direct input, 1 = ÷16 prescaled input.
- gate_real  in  1  precise gate from the datapath, synchronous to clk_50M.
- M_in  in  32  reference count from the datapath, stable while gate_real is low.
- N_in  in  32  input count from the datapath, stable while gate_real is low.
- M_out  out  32  latched reference count.
- N_out  out  32  latched input count; equals N_in<<4 when the result came from the prescaled path.
- range_out  out  1  div_sel value used for the presented result.
- err_noin  out  1  set with a result when no input edge was seen or the timeout fired.
- result_valid  out  1  result available.
- result_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CLEAR, OPEN, CLOSE, EVAL, PRESENT.
- IDLE
  - Go to CLEAR on start, or when cont is high.
  - Clear the switch-used flag.
- CLEAR
  - clr_cnt = 1 for exactly one cycle.
  - Load the gate counter from gate_sel; gate_sel is sampled only here.
  - Next state is OPEN.
- OPEN
  - gate_pre = 1 for exactly the gate length in cycles.
  - Set the seen_rise flag if gate_real rises.
  - Go to CLOSE when the gate counter expires.
- CLOSE
  - gate_pre = 0; the timeout counter runs.
  - If seen_rise = 0 and gate_real = 0 on entry, go to EVAL with the no-input condition.
  - Otherwise go to EVAL on a gate_real falling edge (registered previous value = 1, current = 0).
  - On timeout, go to EVAL with the no-input condition.
- EVAL (one cycle): sample M_in and N_in.
  - No-input condition: latch M_out = M_in, N_out = 0, err_noin = 1; go to PRESENT.
  - div_sel = 0, N_in*4 > M_in (f > 12.5 MHz), switch-used flag = 0: set div_sel = 1 and the switch-used flag; go to CLEAR.
  - div_sel = 1, N_in*128 < M_in (f < 6.25 MHz), switch-used flag = 0: set div_sel = 0 and the switch-used flag; go to CLEAR.
  - Otherwise: latch M_out, N_out (shifted left by 4 if div_sel = 1), range_out = div_sel, err_noin = 0; go to PRESENT.
- PRESENT
  - result_valid = 1; outputs are held stable.
  - On result_valid & result_ready, go to CLEAR if cont is high, else IDLE.
- Arithmetic
  - Range comparisons use 40-bit products; no overflow is possible.
  - N_in<<4 truncates to 32 bits (N_in ≤ 2^28 within spec).
- Range hysteresis
  - The band between 6.25 and 12.5 MHz keeps the current range.
  - At most one range switch per measurement, so at most two gate windows per result.
  - div_sel persists across measurements; only reset forces it to 0.
- start while busy is ignored. Changes on cont take effect only at the IDLE and PRESENT exits.

## Timing
- Reset values: gate_pre = 0, clr_cnt = 0, div_sel = 0, M_out = 0, N_out = 0, range_out = 0, err_noin = 0, result_valid = 0, busy = 0, FSM in IDLE.
- Reset mid-measurement aborts immediately; gate_pre drops asynchronously.
- Start latency: start at cycle t gives clr_cnt at t+1 and gate_pre high over cycles t+2 … t+1+L, where L = gate length.
- EVAL follows the detected gate_real fall by one cycle. result_valid rises the cycle after EVAL.
- A handshake at cycle u drops result_valid at u+1. In continuous mode clr_cnt also pulses at u+1.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.

## Test plan
- 1 MHz input, gate_sel = 00, start pulse -> one window, range_out = 0, N_out ≈ 10_000, M_out ≈ 500_000, result_valid held until result_ready.
- 20 MHz input starting with div_sel = 0 -> two windows, range_out = 1, N_out = N_in<<4 ≈ 200_000 at gate_sel = 00.
- 9 MHz input from either range -> no switch, single window, range_out equals the prior div_sel.
- Input held low, gate_sel = 00 -> err_noin = 1, N_out = 0, result 2 cycles after gate_pre falls. gate_real stuck high -> err_noin = 1 after exactly GATE_TIMEOUT cycles (reduced via parameter).
- cont = 1 with result_ready tied high -> back-to-back measurements, clr_cnt one cycle after each handshake; start pulses while busy have no effect.
- rst asserted during OPEN -> gate_pre = 0 immediately, all outputs at reset values; the next start runs normally.
